// File: rtl/fp_round_pack.sv
// fp_round_pack: two-register rounding/packing stage for a small float format.
// S1 captures the extracted sign/exponent/significand/rounding-bit tuple.
// S2 holds the rounded, packed S/E/F result plus round_up/saturated flags.
// S1 -> S2 advances whenever S2 is empty or being drained, so one tuple per
// cycle can flow and at most two tuples are ever held under backpressure.
module fp_round_pack (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       sign_in,
  input  logic [2:0] exponent,
  input  logic [3:0] significand,
  input  logic       fifth_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       S,
  output logic [2:0] E,
  output logic [3:0] F,
  output logic       round_up,
  output logic       saturated,
  output logic [7:0] sat_count
);

  // Packed rounding result layout: {exp[2:0], sig[3:0], round_up, saturated}
  localparam int RES_W = 9;

  // Round-half-up on the fifth bit. A carry out of the significand renormalises
  // to 1000 with exponent+1; at the largest exponent the result clamps to the
  // maximum magnitude instead of wrapping.
  function automatic logic [RES_W-1:0] round_pack(
    input logic [2:0] exp_i,
    input logic [3:0] sig_i,
    input logic       fifth_i
  );
    logic [RES_W-1:0] res;
    if (!fifth_i) begin
      res = {exp_i, sig_i, 1'b0, 1'b0};
    end else if (sig_i != 4'b1111) begin
      res = {exp_i, sig_i + 4'd1, 1'b1, 1'b0};
    end else if (exp_i != 3'b111) begin
      res = {exp_i + 3'd1, 4'b1000, 1'b1, 1'b0};
    end else begin
      res = {3'b111, 4'b1111, 1'b0, 1'b1};
    end
    return res;
  endfunction

  // Stage 1 registers
  logic       s1_valid_r;
  logic       s1_sign_r;
  logic [2:0] s1_exp_r;
  logic [3:0] s1_sig_r;
  logic       s1_fifth_r;

  // Stage 2 registers (drive the outputs directly)
  logic       s2_valid_r;
  logic       s2_sign_r;
  logic [2:0] s2_exp_r;
  logic [3:0] s2_sig_r;
  logic       s2_round_up_r;
  logic       s2_sat_r;
  logic [7:0] sat_count_r;

  // Handshake and datapath nets
  logic             s2_en_s;
  logic             accept_s;
  logic             deliver_s;
  logic [RES_W-1:0] round_s;

  // Handshake decode: S2 can load when empty or draining; S1 can take a new
  // tuple when empty or when its content is moving into S2.
  always_comb begin
    s2_en_s   = !s2_valid_r || out_ready;
    in_ready  = !s1_valid_r || s2_en_s;
    accept_s  = in_valid && in_ready;
    deliver_s = s2_valid_r && out_ready;
  end

  // Rounding of the tuple currently held in S1.
  always_comb begin
    round_s = round_pack(s1_exp_r, s1_sig_r, s1_fifth_r);
  end

  // Stage 1: capture on accept, otherwise drop the valid flag once S2 takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_exp_r   <= 3'd0;
      s1_sig_r   <= 4'd0;
      s1_fifth_r <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_sign_r  <= sign_in;
      s1_exp_r   <= exponent;
      s1_sig_r   <= significand;
      s1_fifth_r <= fifth_bit;
    end else if (s2_en_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2: register the packed result; everything holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r    <= 1'b0;
      s2_sign_r     <= 1'b0;
      s2_exp_r      <= 3'd0;
      s2_sig_r      <= 4'd0;
      s2_round_up_r <= 1'b0;
      s2_sat_r      <= 1'b0;
    end else if (s2_en_s) begin
      s2_valid_r    <= s1_valid_r;
      s2_sign_r     <= s1_sign_r;
      s2_exp_r      <= round_s[8:6];
      s2_sig_r      <= round_s[5:2];
      s2_round_up_r <= round_s[1];
      s2_sat_r      <= round_s[0];
    end
  end

  // Count delivered saturated results; free-running 8-bit wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count_r <= 8'd0;
    end else if (deliver_s && s2_sat_r) begin
      sat_count_r <= sat_count_r + 8'd1;
    end
  end

  assign out_valid = s2_valid_r;
  assign S         = s2_sign_r;
  assign E         = s2_exp_r;
  assign F         = s2_sig_r;
  assign round_up  = s2_round_up_r;
  assign saturated = s2_sat_r;
  assign sat_count = sat_count_r;

endmodule

// File: tb/tb_fp_round_pack.sv
// Self-checking bench for fp_round_pack: directed cases, a backpressured
// stream, random traffic against a queue scoreboard, reset flush and
// sat_count wrap.
module tb_fp_round_pack;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       sign_in;
  logic [2:0] exponent;
  logic [3:0] significand;
  logic       fifth_bit;
  logic       out_valid;
  logic       out_ready;
  logic       S;
  logic [2:0] E;
  logic [3:0] F;
  logic       round_up;
  logic       saturated;
  logic [7:0] sat_count;

  fp_round_pack dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exponent(exponent), .significand(significand),
    .fifth_bit(fifth_bit),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .E(E), .F(F), .round_up(round_up), .saturated(saturated),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_deliv = 0;
  logic [9:0]  q[$];          // expected {S,E,F,round_up,saturated}
  logic [7:0]  sat_model = 8'd0;
  bit          hold_pending = 1'b0;
  logic [10:0] held;
  bit          last_ready;

  // Reference: add the rounding bit to the 4-bit significand as an integer;
  // overflow to 16 means renormalise, or clamp at the top exponent.
  function automatic logic [9:0] ref_pack(input logic s, input logic [2:0] ex,
                                          input logic [3:0] sg, input logic fb);
    int mag;
    int e;
    logic [3:0] f;
    logic ru, sat;
    mag = int'(sg) + int'(fb);
    e   = int'(ex);
    ru  = fb;
    sat = 1'b0;
    f   = 4'(mag);
    if (mag == 16) begin
      if (e == 7) begin
        f = 4'd15; ru = 1'b0; sat = 1'b1;
      end else begin
        e = e + 1; f = 4'd8;
      end
    end
    return {s, 3'(e), f, ru, sat};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check at the falling edge, update the scoreboard for the
  // transfers that the next rising edge will perform, return #1 after it.
  task automatic tick(output bit acc);
    logic [9:0] e;
    @(negedge clk);
    if (hold_pending)
      chk("hold_stable", 32'({out_valid, S, E, F, round_up, saturated}), 32'(held));
    hold_pending = out_valid && !out_ready;
    held = {out_valid, S, E, F, round_up, saturated};
    last_ready = in_ready;
    chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
    chk("sat_count", 32'(sat_count), 32'(sat_model));
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("result", 32'({S, E, F, round_up, saturated}), 32'(e));
        if (e[0]) sat_model = sat_model + 8'd1;
        n_deliv++;
      end
    end
    acc = in_valid && in_ready;
    if (acc) q.push_back(ref_pack(sign_in, exponent, significand, fifth_bit));
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic s, input logic [2:0] ex,
                        input logic [3:0] sg, input logic fb);
    in_valid = v; sign_in = s; exponent = ex; significand = sg; fifth_bit = fb;
  endtask

  // Single tuple with out_ready high: checks 2-cycle latency and fields.
  task automatic single(input string tag, input logic s, input logic [2:0] ex,
                        input logic [3:0] sg, input logic fb,
                        input logic [2:0] xe, input logic [3:0] xf,
                        input logic xru, input logic xsat);
    bit acc;
    out_ready = 1'b1;
    set_in(1'b1, s, ex, sg, fb);
    tick(acc);
    chk({tag, "_accept"}, 32'(acc), 32'd1);
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    tick(acc);
    chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
    chk({tag, "_fields"}, 32'({S, E, F, round_up, saturated}),
        32'({s, xe, xf, xru, xsat}));
    tick(acc);
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    bit acc;
    int idx;
    int acc_cnt;
    int d0;
    bit saw_block;

    rst_n = 1'b0;
    out_ready = 1'b1;
    set_in(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'({out_valid, S, E, F, round_up, saturated, sat_count}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // Directed rounding cases
    single("round_inc", 1'b0, 3'd3, 4'b1010, 1'b1, 3'd3, 4'b1011, 1'b1, 1'b0);
    single("renorm",    1'b1, 3'd4, 4'b1111, 1'b1, 3'd5, 4'b1000, 1'b1, 1'b0);
    single("no_round",  1'b1, 3'd2, 4'b0110, 1'b0, 3'd2, 4'b0110, 1'b0, 1'b0);
    single("zero",      1'b1, 3'd0, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0);
    single("saturate",  1'b0, 3'd7, 4'b1111, 1'b1, 3'd7, 4'b1111, 1'b0, 1'b1);
    chk("sat_count_one", 32'(sat_count), 32'd1);

    // Five distinct tuples with out_ready low for cycles 3..6
    idx = 0;
    saw_block = 1'b0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      if (idx < 5) set_in(1'b1, idx[0], 3'(idx + 1), 4'(idx * 3 + 9), 1'b1);
      else in_valid = 1'b0;
      tick(acc);
      if (!last_ready) saw_block = 1'b1;
      if (acc) idx++;
    end
    chk("stream_all_sent", 32'(idx), 32'd5);
    chk("stream_all_recv", 32'(q.size()), 32'd0);
    chk("stream_blocked", 32'(saw_block), 32'd1);

    // Random traffic against the scoreboard
    for (int c = 0; c < 400; c++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom), 3'($urandom),
             4'($urandom), 1'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      tick(acc);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick(acc);
    chk("random_drained", 32'(q.size()), 32'd0);

    // Reset with two tuples in flight
    out_ready = 1'b0;
    set_in(1'b1, 1'b0, 3'd7, 4'b1111, 1'b1);
    tick(acc);
    set_in(1'b1, 1'b1, 3'd1, 4'b0011, 1'b1);
    tick(acc);
    in_valid = 1'b0;
    chk("inflight_two", 32'(q.size()), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_satcnt", 32'(sat_count), 32'd0);
    q.delete();
    sat_model = 8'd0;
    hold_pending = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      tick(acc);
      chk("no_stale", 32'(out_valid), 32'd0);
    end

    // 256 saturating results wrap sat_count to zero
    acc_cnt = 0;
    d0 = n_deliv;
    for (int c = 0; c < 300 && (n_deliv - d0) < 256; c++) begin
      if (acc_cnt < 256) set_in(1'b1, 1'($urandom), 3'd7, 4'b1111, 1'b1);
      else in_valid = 1'b0;
      tick(acc);
      if (acc) acc_cnt++;
      if ((n_deliv - d0) == 255) chk("sat_count_255", 32'(sat_count), 32'd255);
    end
    in_valid = 1'b0;
    chk("sat_deliv_256", 32'(n_deliv - d0), 32'd256);
    chk("sat_count_wrap", 32'(sat_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_round_pack.md
FP_ROUND_PACK -- requirements
Module: fp_round_pack

Interface
REQ-001 Parameter: none; all widths fixed.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream presents a sign/exponent/significand/rounding-bit tuple.
REQ-005 in_ready  output  1  stage can accept a tuple this cycle.
REQ-006 sign_in  input  1  sign of the original 12-bit two's complement sample.
REQ-007 exponent  input  3  exponent from the exponent/significand extraction stage.
REQ-008 significand  input  4  truncated significand from the extraction stage.
REQ-009 fifth_bit  input  1  rounding bit from the extraction stage.
REQ-010 out_valid  output  1  S/E/F outputs hold a packed result.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 S  output  1  packed sign.
REQ-013 E  output  3  packed exponent.
REQ-014 F  output  4  packed significand.
REQ-015 round_up  output  1  the current result had its significand incremented.
REQ-016 saturated  output  1  the current result was clamped to maximum magnitude.
REQ-017 sat_count  output  8  count of saturated results delivered.

Function
REQ-018 Transfer rules: input accepted when in_valid && in_ready; output delivered when out_valid && out_ready.
REQ-019 The block is a two-register pipeline: S1 captures the input tuple; S2 holds the packed result and drives the outputs.
REQ-020 S2 load enable: s2_en = !out_valid || out_ready; on s2_en, S2 takes S1 contents and S1's valid flag.
REQ-021 in_ready = !s1_valid || s2_en; combinational; no combinational path from in_valid to in_ready.
REQ-022 S1 loads on input accept; otherwise S1 clears its valid flag when it moves into S2.
REQ-023 Latency: result appears on out_valid 2 cycles after accept with out_ready held high; sustained throughput 1 tuple/cycle.
REQ-024 Under backpressure (out_ready=0), S/E/F, round_up, saturated and out_valid hold stable; at most 2 tuples are in flight; no tuple is dropped or duplicated.
REQ-025 Rounding is computed from S1 contents and registered into S2.
REQ-026 fifth_bit=0: F=significand, E=exponent, round_up=0, saturated=0.
REQ-027 fifth_bit=1 and significand<4'b1111: F=significand+1, E=exponent, round_up=1.
REQ-028 fifth_bit=1, significand=4'b1111, exponent<7: F=4'b1000, E=exponent+1, round_up=1.
REQ-029 fifth_bit=1, significand=4'b1111, exponent=7: F=4'b1111, E=3'b111, round_up=0, saturated=1.
REQ-030 S=sign_in in all cases; a magnitude of zero (exponent=0, significand=0, fifth_bit=0) packs as S=sign_in, E=0, F=0.
REQ-031 sat_count increments by 1 on each delivered output with saturated=1, wraps 255->0, and never saturates.
REQ-032 An input accept and an output delivery in the same cycle are both honoured.

Reset
REQ-033 While rst_n=0: s1_valid=0, out_valid=0, S=0, E=0, F=0, round_up=0, saturated=0, sat_count=0.
REQ-034 Reset asserted mid-operation discards all in-flight tuples immediately; no output is delivered for them.
REQ-035 in_ready=1 from the first cycle after rst_n deasserts.

Verification
REQ-036 Single tuple (sign 0, exp 3, sig 1010, fifth 1) with out_ready=1 -> 2 cycles later out_valid=1, S=0, E=3, F=1011, round_up=1.
REQ-037 Tuple (sign 1, exp 4, sig 1111, fifth 1) -> S=1, E=5, F=1000, round_up=1, saturated=0.
REQ-038 Tuple (exp 7, sig 1111, fifth 1) -> E=7, F=1111, saturated=1, and sat_count goes 0->1 on delivery.
REQ-039 Stream 5 distinct tuples with out_ready low for cycles 3-6 -> in_ready=0 once 2 tuples are held, outputs stay stable, all 5 results delivered in order with no loss.
REQ-040 Deliver 256 saturating results -> sat_count reads 0.
REQ-041 Drop rst_n with 2 tuples in flight -> out_valid=0 and sat_count=0 asynchronously, and no stale result appears after release.
